// File: rtl/ram_arb_pkg.sv
// Shared encodings for the two-requester RAM arbiter: FSM states and requester IDs.
// The CLEAR state only exists when RAM_ARB_CLEAR_EN is defined.
package ram_arb_pkg;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1
`ifdef RAM_ARB_CLEAR_EN
        ,
        ST_CLEAR = 2'd2
`endif
    } state_t;

`ifdef RAM_ARB_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin pick: combinational winner, registered "granted last" pointer
// that advances only when the caller commits a grant.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic upd,
    output logic win,
    output logic any
);

    logic last_r;

    // Winner selection: a lone requester wins, contention goes to the one not served last
    always_comb begin
        any = req_a | req_b;
        if (req_a && req_b) begin
            win = ~last_r;
        end else if (req_b) begin
            win = REQ_B;
        end else begin
            win = REQ_A;
        end
    end

    // Last-granted pointer; starts at B so A wins the first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= REQ_B;
        end else if (upd) begin
            last_r <= win;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises commands from requesters A and B onto a single-port RAM, one access per
// two cycles. Define RAM_ARB_CLEAR_EN to zero every RAM word after each reset.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_t            state_r;
    logic              cmd_we_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [DATA_W-1:0] cmd_wdata_r;
    logic              sel_r;
    logic              a_gnt_r;
    logic              b_gnt_r;
    logic              a_rvalid_r;
    logic              b_rvalid_r;
    logic [DATA_W-1:0] a_rdata_r;
    logic [DATA_W-1:0] b_rdata_r;
    logic              win_s;
    logic              any_s;
    logic              upd_s;

`ifdef RAM_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    logic [ADDR_W-1:0] cnt_r;
    logic              busy_r;
    assign busy = busy_r;
`else
    assign busy = 1'b0;
`endif

    assign upd_s = (state_r == ST_IDLE) && any_s;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst   (rst),
        .req_a (a_req),
        .req_b (b_req),
        .upd   (upd_s),
        .win   (win_s),
        .any   (any_s)
    );

    // Sequencer: clear sweep, arbitration with command latch, read-data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RESET;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= '0;
            cmd_wdata_r <= '0;
            sel_r       <= REQ_A;
            a_gnt_r     <= 1'b0;
            b_gnt_r     <= 1'b0;
            a_rvalid_r  <= 1'b0;
            b_rvalid_r  <= 1'b0;
            a_rdata_r   <= '0;
            b_rdata_r   <= '0;
`ifdef RAM_ARB_CLEAR_EN
            cnt_r       <= '0;
            busy_r      <= 1'b1;
`endif
        end else begin
            a_gnt_r    <= 1'b0;
            b_gnt_r    <= 1'b0;
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            case (state_r)
`ifdef RAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end
                end
`endif
                ST_IDLE: begin
                    if (any_s) begin
                        state_r <= ST_SERVE;
                        sel_r   <= win_s;
                        if (win_s == REQ_A) begin
                            cmd_we_r    <= a_we;
                            cmd_addr_r  <= a_addr;
                            cmd_wdata_r <= a_wdata;
                            a_gnt_r     <= 1'b1;
                        end else begin
                            cmd_we_r    <= b_we;
                            cmd_addr_r  <= b_addr;
                            cmd_wdata_r <= b_wdata;
                            b_gnt_r     <= 1'b1;
                        end
                    end
                end
                ST_SERVE: begin
                    state_r <= ST_IDLE;
                    if (!cmd_we_r) begin
                        if (sel_r == REQ_A) begin
                            a_rdata_r  <= ram_rdata;
                            a_rvalid_r <= 1'b1;
                        end else begin
                            b_rdata_r  <= ram_rdata;
                            b_rvalid_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_RESET;
                end
            endcase
        end
    end

    // RAM pin decode; held low during reset so an in-flight write never lands
    always_comb begin
        ram_ena   = 1'b0;
        ram_wena  = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst) begin
            ram_ena   = 1'b0;
            ram_wena  = 1'b0;
        end else begin
            case (state_r)
                ST_SERVE: begin
                    ram_ena   = 1'b1;
                    ram_wena  = cmd_we_r;
                    ram_addr  = cmd_addr_r;
                    ram_wdata = cmd_wdata_r;
                end
`ifdef RAM_ARB_CLEAR_EN
                ST_CLEAR: begin
                    ram_ena   = 1'b1;
                    ram_wena  = 1'b1;
                    ram_addr  = cnt_r;
                    ram_wdata = '0;
                end
`endif
                ST_IDLE: begin
                    ram_ena   = 1'b0;
                    ram_wena  = 1'b0;
                end
                default: begin
                    ram_ena   = 1'b0;
                    ram_wena  = 1'b0;
                end
            endcase
        end
    end

    assign a_gnt    = a_gnt_r;
    assign b_gnt    = b_gnt_r;
    assign a_rvalid = a_rvalid_r;
    assign b_rvalid = b_rvalid_r;
    assign a_rdata  = a_rdata_r;
    assign b_rdata  = b_rdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a 32x32 RAM model: directed vector table, corner-case
// sequences and a randomized run against a transaction-level reference.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        ram_ena, ram_wena, busy;
    logic [4:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] ref_mem [32];
    logic [31:0] exp_a_rd, exp_b_rd;

    ram_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM model: unwritten words read as a recognisable non-zero pattern
    logic [31:0] mem [32];
    bit          written [32];

    function automatic logic [31:0] pattern(input logic [4:0] a);
        return 32'hA5A5_0000 | {27'd0, a};
    endfunction

    always @(posedge clk) begin
        if (ram_ena && ram_wena) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
        end
    end

    assign ram_rdata = (ram_ena && !ram_wena) ?
                       (written[ram_addr] ? mem[ram_addr] : pattern(ram_addr)) : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_a(input logic r, input logic w, input logic [4:0] ad, input logic [31:0] d);
        a_req = r; a_we = w; a_addr = ad; a_wdata = d;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [4:0] ad, input logic [31:0] d);
        b_req = r; b_we = w; b_addr = ad; b_wdata = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_gnt"}, 32'(a_gnt), 32'd0);
        chk({tag, "_b_gnt"}, 32'(b_gnt), 32'd0);
        chk({tag, "_a_rvalid"}, 32'(a_rvalid), 32'd0);
        chk({tag, "_b_rvalid"}, 32'(b_rvalid), 32'd0);
        chk({tag, "_a_rdata"}, a_rdata, 32'd0);
        chk({tag, "_b_rdata"}, b_rdata, 32'd0);
        chk({tag, "_ram_ena"}, 32'(ram_ena), 32'd0);
        chk({tag, "_ram_wena"}, 32'(ram_wena), 32'd0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
`ifdef RAM_ARB_CLEAR_EN
        chk({tag, "_busy"}, 32'(busy), 32'd1);
`else
        chk({tag, "_busy"}, 32'(busy), 32'd0);
`endif
    endtask

    // One access from an idle arbiter: grant next cycle, rvalid the cycle after
    task automatic xfer(input logic who, input logic we, input logic [4:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp);
        logic got;
        int   n;
        if (who == REQ_A) drive_a(1'b1, we, addr, wdata);
        else              drive_b(1'b1, we, addr, wdata);
        step();
        got = (who == REQ_A) ? a_gnt : b_gnt;
        chk("gnt_latency", 32'(got), 32'd1);
        n = 0;
        while (!got && n < 8) begin
            step();
            got = (who == REQ_A) ? a_gnt : b_gnt;
            n++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: no grant for requester %0d within budget", who);
        end
        chk("other_gnt", 32'((who == REQ_A) ? b_gnt : a_gnt), 32'd0);
        chk("ram_ena", 32'(ram_ena), 32'd1);
        chk("ram_wena", 32'(ram_wena), 32'(we));
        chk("ram_addr", 32'(ram_addr), 32'(addr));
        if (we) chk("ram_wdata", ram_wdata, wdata);
        if (who == REQ_A) drive_a(1'b0, 1'b0, 5'd0, 32'd0);
        else              drive_b(1'b0, 1'b0, 5'd0, 32'd0);
        if (we) ref_mem[addr] = wdata;
        step();
        if (!we) begin
            if (who == REQ_A) exp_a_rd = exp;
            else              exp_b_rd = exp;
        end
        chk("a_rvalid", 32'(a_rvalid), 32'((who == REQ_A) && !we));
        chk("b_rvalid", 32'(b_rvalid), 32'((who == REQ_B) && !we));
        chk("a_rdata", a_rdata, exp_a_rd);
        chk("b_rdata", b_rdata, exp_b_rd);
    endtask

    typedef struct {
        logic        who;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   order [8];
        int   gcyc [8];
        int   got_n, budget, n;
        logic pa, pb, wa, wb, m_last, w, eg_a, eg_b, erv_a, erv_b;
        logic [4:0]  ca_addr, cb_addr, e_addr;
        logic [31:0] ca_data, cb_data, rv_data;
        int   free_edge, rv_edge, e;
        logic rv_who;

        vecs[0] = '{REQ_A, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{REQ_A, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
        vecs[2] = '{REQ_B, 1'b1, 5'd9,  32'h12345678, 32'h0};
        vecs[3] = '{REQ_B, 1'b0, 5'd9,  32'h0,        32'h12345678};
        vecs[4] = '{REQ_A, 1'b0, 5'd9,  32'h0,        32'h12345678};
        vecs[5] = '{REQ_B, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
        vecs[6] = '{REQ_A, 1'b1, 5'd0,  32'h00000001, 32'h0};
        vecs[7] = '{REQ_B, 1'b1, 5'd31, 32'h80000000, 32'h0};
        vecs[8] = '{REQ_A, 1'b0, 5'd31, 32'h0,        32'h80000000};
        vecs[9] = '{REQ_B, 1'b0, 5'd0,  32'h0,        32'h00000001};

        for (int i = 0; i < 32; i++) ref_mem[i] = pattern(5'(i));
        exp_a_rd = 32'd0;
        exp_b_rd = 32'd0;
        drive_a(1'b0, 1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;

        step();
        step();
        chk_reset_outputs("reset");

`ifdef RAM_ARB_CLEAR_EN
        rst = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            chk("clear_busy", 32'(busy), 32'd1);
            chk("clear_ena", 32'(ram_ena & ram_wena), 32'd1);
            chk("clear_addr", 32'(ram_addr), 32'(i));
            chk("clear_wdata", ram_wdata, 32'd0);
            step();
        end
        chk("clear_done_busy", 32'(busy), 32'd0);
        chk("clear_done_ena", 32'(ram_ena), 32'd0);
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
        xfer(REQ_A, 1'b0, 5'd7, 32'd0, 32'd0);
`else
        rst = 1'b0;
        drive_a(1'b1, 1'b1, 5'd7, 32'hCAFE0007);
        #1;
        chk("nomacro_busy", 32'(busy), 32'd0);
        step();
        chk("first_idle_gnt", 32'(a_gnt), 32'd1);
        chk("first_idle_addr", 32'(ram_addr), 32'd7);
        drive_a(1'b0, 1'b0, 5'd0, 32'd0);
        ref_mem[7] = 32'hCAFE0007;
        step();
        chk("first_idle_norv", 32'(a_rvalid), 32'd0);
        xfer(REQ_A, 1'b0, 5'd7, 32'd0, 32'hCAFE0007);
`endif

        for (int i = 0; i < 10; i++)
            xfer(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

        // Contention: A wins first, B two cycles later
        drive_a(1'b1, 1'b1, 5'd1, 32'h11);
        drive_b(1'b1, 1'b1, 5'd2, 32'h22);
        step();
        chk("cont_a_gnt", 32'(a_gnt), 32'd1);
        chk("cont_b_gnt0", 32'(b_gnt), 32'd0);
        chk("cont_wdata_a", ram_wdata, 32'h11);
        drive_a(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("cont_gap", 32'({a_gnt, b_gnt}), 32'd0);
        step();
        chk("cont_b_gnt", 32'(b_gnt), 32'd1);
        chk("cont_addr_b", 32'(ram_addr), 32'd2);
        chk("cont_wdata_b", ram_wdata, 32'h22);
        drive_b(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        ref_mem[1] = 32'h11;
        ref_mem[2] = 32'h22;
        xfer(REQ_A, 1'b0, 5'd1, 32'd0, 32'h11);
        xfer(REQ_B, 1'b0, 5'd2, 32'd0, 32'h22);

        // Fairness: both hold req for 8 grants
        drive_a(1'b1, 1'b0, 5'd1, 32'd0);
        drive_b(1'b1, 1'b0, 5'd2, 32'd0);
        got_n = 0;
        budget = 0;
        while (got_n < 8 && budget < 40) begin
            step();
            budget++;
            if (a_gnt && b_gnt) begin
                checks++;
                errors++;
                $display("FAIL fair_double_gnt: both grants high at cycle %0d", cyc);
            end
            if (a_gnt || b_gnt) begin
                order[got_n] = b_gnt ? 1 : 0;
                gcyc[got_n] = cyc;
                got_n++;
            end
        end
        drive_a(1'b0, 1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        chk("fair_count", 32'(got_n), 32'd8);
        for (int i = 0; i < got_n; i++) begin
            chk("fair_order", 32'(order[i]), 32'(i % 2));
            if (i > 0) chk("fair_gap", 32'(gcyc[i] - gcyc[i-1]), 32'd2);
        end

        // Randomized traffic against a transaction-level reference
        pa = 1'b0; pb = 1'b0; wa = 1'b0; wb = 1'b0;
        ca_addr = 5'd0; cb_addr = 5'd0; ca_data = 32'd0; cb_data = 32'd0;
        m_last = REQ_B;
        free_edge = cyc + 1;
        rv_edge = -1;
        rv_who = REQ_A;
        rv_data = 32'd0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && i < 390 && $urandom_range(0, 2) == 0) begin
                pa = 1'b1;
                wa = 1'($urandom_range(0, 1));
                ca_addr = 5'($urandom_range(0, 31));
                ca_data = $urandom;
            end
            if (!pb && i < 390 && $urandom_range(0, 2) == 0) begin
                pb = 1'b1;
                wb = 1'($urandom_range(0, 1));
                cb_addr = 5'($urandom_range(0, 31));
                cb_data = $urandom;
            end
            drive_a(pa, wa, ca_addr, ca_data);
            drive_b(pb, wb, cb_addr, cb_data);
            e = cyc + 1;
            eg_a = 1'b0; eg_b = 1'b0; erv_a = 1'b0; erv_b = 1'b0;
            e_addr = 5'd0;
            if (rv_edge == e) begin
                if (rv_who == REQ_A) begin erv_a = 1'b1; exp_a_rd = rv_data; end
                else                 begin erv_b = 1'b1; exp_b_rd = rv_data; end
            end
            if (e >= free_edge && (pa || pb)) begin
                w = (pa && pb) ? ~m_last : (pa ? REQ_A : REQ_B);
                m_last = w;
                free_edge = e + 2;
                if (w == REQ_A) begin
                    eg_a = 1'b1;
                    e_addr = ca_addr;
                    if (wa) ref_mem[ca_addr] = ca_data;
                    else begin rv_edge = e + 1; rv_who = REQ_A; rv_data = ref_mem[ca_addr]; end
                end else begin
                    eg_b = 1'b1;
                    e_addr = cb_addr;
                    if (wb) ref_mem[cb_addr] = cb_data;
                    else begin rv_edge = e + 1; rv_who = REQ_B; rv_data = ref_mem[cb_addr]; end
                end
            end
            step();
            chk("rnd_a_gnt", 32'(a_gnt), 32'(eg_a));
            chk("rnd_b_gnt", 32'(b_gnt), 32'(eg_b));
            chk("rnd_a_rvalid", 32'(a_rvalid), 32'(erv_a));
            chk("rnd_b_rvalid", 32'(b_rvalid), 32'(erv_b));
            chk("rnd_a_rdata", a_rdata, exp_a_rd);
            chk("rnd_b_rdata", b_rdata, exp_b_rd);
            chk("rnd_ram_ena", 32'(ram_ena), 32'(eg_a | eg_b));
            if (eg_a || eg_b) chk("rnd_ram_addr", 32'(ram_addr), 32'(e_addr));
            if (a_gnt) pa = 1'b0;
            if (b_gnt) pb = 1'b0;
        end
        drive_a(1'b0, 1'b0, 5'd0, 32'd0);
        drive_b(1'b0, 1'b0, 5'd0, 32'd0);

        // Reset during the grant cycle of a write: the write must not land
        drive_a(1'b1, 1'b1, 5'd3, 32'h55);
        step();
        chk("midrst_gnt", 32'(a_gnt), 32'd1);
        rst = 1'b1;
        drive_a(1'b0, 1'b0, 5'd0, 32'd0);
        step();
        exp_a_rd = 32'd0;
        exp_b_rd = 32'd0;
        chk_reset_outputs("midrst");
        rst = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk("midrst_clear_len", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
`else
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
`endif
        chk("midrst_norv", 32'(a_rvalid), 32'd0);
        xfer(REQ_A, 1'b0, 5'd3, 32'd0, ref_mem[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and access sequencer for the 32×32 single-port RAM. It serialises read and write commands from requester A and requester B onto the RAM's `ena`/`wena`/`addr`/`data_in` pins and returns registered read data with a valid pulse. An optional post-reset sequencer clears every RAM word to zero before any requester is served. It sits between the two bus masters and the RAM instance, and it is the only driver of the RAM control pins.

## Interface
Parameters:
- `ADDR_W`, 5: RAM address width; DEPTH = 2**ADDR_W = 32.
- `DATA_W`, 32: RAM data width.

Ports (X ∈ {a, b}):
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `X_req`  in  1: request; hold it, with `X_we`, `X_addr` and `X_wdata` stable, until `X_gnt` is seen.
- `X_we`  in  1: 1 = write, 0 = read.
- `X_addr`  in  ADDR_W: target word.
- `X_wdata`  in  DATA_W: write data.
- `X_gnt`  out  1: one-cycle pulse; the command is on the RAM pins in this cycle.
- `X_rvalid`  out  1: one-cycle pulse; `X_rdata` is valid (reads only).
- `X_rdata`  out  DATA_W: registered read data; holds its value until the next read for X.
- `ram_ena`, `ram_wena`  out  1: drive RAM `ena` and `wena`.
- `ram_addr`  out  ADDR_W: drives RAM `addr`.
- `ram_wdata`  out  DATA_W: drives RAM `data_in`.
- `ram_rdata`  in  DATA_W: from RAM `data_out`; combinational, high-Z when `ram_ena` = 0.
- `busy`  out  1: clear sequence in progress.

## Operation
- FSM states:
  - CLEAR: only when the macro is defined.
  - IDLE: arbitrate.
  - SERVE: one cycle; the latched command is on the RAM pins.
- RAM pins are decoded from registered state, and all of them are forced to 0 while `rst` = 1:
  - SERVE: `ram_ena` = 1; `ram_wena`, `ram_addr` and `ram_wdata` come from the latched command.
  - CLEAR: `ram_ena` = 1, `ram_wena` = 1, `ram_addr` = cnt, `ram_wdata` = 0.
  - IDLE: all four pins are 0.
- IDLE → SERVE on any `X_req`. At that edge the arbiter latches the winner's `we`/`addr`/`wdata`, sets `sel`, and registers `X_gnt` = 1.
- Round-robin rule:
  - Only one requester asserted: it wins.
  - Both asserted: the requester not granted last wins.
  - `last` resets to B, so A wins the first contention.
- SERVE → IDLE unconditionally.
  - Write: the RAM captures the data at this edge.
  - Read: `ram_rdata` is captured into `sel`'s `X_rdata` at this edge, and `X_rvalid` is registered high.
- Requests are never granted in SERVE or CLEAR. A held `req` is serviced on the next IDLE cycle.
- Only the selected requester sees `gnt`/`rvalid`. The other requester's outputs are unaffected.
- `rst` at any point returns the FSM to CLEAR (or IDLE without the macro), sets cnt = 0 and `last` = B, and discards any latched command. A write already on the pins at that edge does not complete.
- Reset values:
  - `X_gnt`, `X_rvalid`: 0.
  - `X_rdata`: 0.
  - RAM pins: 0.
  - `busy`: 1 with CLEAR, 0 without.

## Timing
- Request sampled high in IDLE cycle N:
  - `gnt` and RAM command in cycle N+1.
  - Write lands at the end of N+1.
  - `rvalid`/`rdata` in cycle N+2.
- Maximum throughput is one access per 2 cycles. A requester that keeps `req` high after `gnt` issues a new access.
- Back-to-back A and B contention grants alternate A, B, A, … every 2 cycles.
- CLEAR behaviour:
  - cnt runs 0 → DEPTH−1, one write per cycle, for 32 cycles after `rst` falls.
  - At the edge where cnt = DEPTH−1, the FSM moves to IDLE and `busy` falls.
  - cnt is ADDR_W bits wide; the terminal count is detected explicitly and no wrap is relied on.

## Configuration
- Macro: `RAM_ARB_CLEAR_EN`.
- Defined: the CLEAR state and cnt exist. After every reset, 32 zero-writes run and `busy` is high throughout. The first grant can occur in cycle 33 after `rst` falls.
- Undefined: no CLEAR state and no counter. `busy` is tied to 0, RAM contents after reset are undefined, and the first grant can occur in the cycle after the first IDLE cycle.

## Structure
- Package `ram_arb_pkg`: FSM state encodings, and the requester IDs `REQ_A` = 0 and `REQ_B` = 1.
- Sub-module `rr_arb2` (combinational winner plus a registered `last` pointer with an update enable) is instantiated once.
- The FSM, command latch, clear counter and read-data capture all live in `ram_arbiter`.

## Test plan
- Reset then clear (macro on): hold `rst` for 2 cycles, then release.
  - Required: `busy` high for exactly 32 cycles, and `ram_addr` steps 0..31 with `ram_wdata` = 0.
  - Then A reads addr 7 and gets `a_rdata` = 0.
- Single write/read: A writes 0xDEADBEEF to addr 5, then reads addr 5.
  - Required: `a_gnt` one cycle after the req, `a_rvalid` 2 cycles after the req, `a_rdata` = 0xDEADBEEF, and `b_*` outputs stay at 0.
- Contention: A and B hold `req` together (A writes 0x11 to addr 1, B writes 0x22 to addr 2).
  - Required: A is granted first, B 2 cycles later. Reads of addr 1 and 2 return 0x11 and 0x22.
- Fairness: A and B hold `req` continuously for 8 grants.
  - Required: grant order A, B, A, B, A, B, A, B, with no gap longer than 2 cycles.
- Reset mid-access: assert `rst` in the `gnt` cycle of A's write of 0x55 to addr 3.
  - Required: no `rvalid`, and all outputs at reset values the next cycle.
  - After the clear sequence, addr 3 reads 0.
- Macro off: after reset, `busy` = 0. A `req` in the first IDLE cycle gets `a_gnt` in the next cycle.
